// File: rtl/fall_timer.sv
// Gravity tick generator: counts vsync frames, derives level from score, pulses drop_tick.
// Optional soft-drop acceleration is enabled by defining FALL_TIMER_SOFT_DROP_EN.
module fall_timer #(
   parameter int BASE_FRAMES      = 48,
   parameter int STEP_FRAMES      = 3,
   parameter int MIN_FRAMES       = 2,
   parameter int POINTS_PER_LEVEL = 1000,
   parameter int MAX_LEVEL        = 15,
   parameter int SOFT_FRAMES      = 2
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic [19:0] points_in,
   input  logic        lock_en,
   input  logic        soft_drop,
   input  logic        pause,
   output logic        drop_tick,
   output logic [3:0]  level,
   output logic [5:0]  frame_period
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [19:0] PPL_C  = 20'(POINTS_PER_LEVEL);
   localparam logic [3:0]  MAXL_C = 4'(MAX_LEVEL);

   state_t      state_q;
   logic        vs_q;
   logic        frame_edge_s;
   logic [19:0] acc_q;
   logic [3:0]  cnt_q;
   logic [3:0]  level_q;
   logic [5:0]  period_q;
   logic [5:0]  period_d;
   logic [5:0]  frame_cnt_q;
   logic [5:0]  frame_cnt_d;
   logic        tick_q;
   logic        tick_d;
   int          base_int_s;
   logic [5:0]  base_s;

   assign frame_edge_s = vsync_in & ~vs_q;

   // Drop period from level; signed arithmetic so a large level clamps instead of wrapping
   always_comb begin
      base_int_s = BASE_FRAMES - STEP_FRAMES * int'(level_q);
      if (base_int_s < MIN_FRAMES) begin
         base_s = 6'(MIN_FRAMES);
      end else begin
         base_s = 6'(base_int_s);
      end
`ifdef FALL_TIMER_SOFT_DROP_EN
      if (soft_drop && (base_s > 6'(SOFT_FRAMES))) begin
         period_d = 6'(SOFT_FRAMES);
      end else begin
         period_d = base_s;
      end
`else
      period_d = base_s;
`endif
   end

`ifndef FALL_TIMER_SOFT_DROP_EN
   logic unused_s;
   assign unused_s = soft_drop ^ SOFT_FRAMES[0];
`endif

   // Frame counter next state: lock beats pause beats frame edge
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      tick_d      = 1'b0;
      if (lock_en) begin
         frame_cnt_d = 6'd0;
      end else if (pause) begin
         frame_cnt_d = frame_cnt_q;
      end else if (frame_edge_s) begin
         if (({1'b0, frame_cnt_q} + 7'd1) >= {1'b0, period_q}) begin
            frame_cnt_d = 6'd0;
            tick_d      = 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + 6'd1;
         end
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Edge detector, period register and frame counter
   always_ff @(posedge pclk) begin
      if (rst) begin
         vs_q        <= 1'b1;
         period_q    <= 6'(BASE_FRAMES);
         frame_cnt_q <= 6'd0;
         tick_q      <= 1'b0;
      end else begin
         vs_q        <= vsync_in;
         period_q    <= period_d;
         frame_cnt_q <= frame_cnt_d;
         tick_q      <= tick_d;
      end
   end

   // Level FSM: repeated subtraction of the per-level score, once per frame
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= 20'd0;
         cnt_q   <= 4'd0;
         level_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_edge_s) begin
                  acc_q   <= points_in;
                  cnt_q   <= 4'd0;
                  state_q <= CALC;
               end
            end
            CALC: begin
               if ((acc_q >= PPL_C) && (cnt_q < MAXL_C)) begin
                  acc_q <= acc_q - PPL_C;
                  cnt_q <= cnt_q + 4'd1;
               end else begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               level_q <= cnt_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign drop_tick    = tick_q;
   assign level        = level_q;
   assign frame_period = period_q;

endmodule

// File: tb/tb_fall_timer.sv
// Scoreboard bench for fall_timer: per-frame tick expectations are queued when vsync is driven.
module tb_fall_timer;

   logic        pclk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync_in = 1'b1;
   logic [19:0] points_in = 20'd0;
   logic        lock_en = 1'b0;
   logic        soft_drop = 1'b0;
   logic        pause = 1'b0;
   logic        drop_tick;
   logic [3:0]  level;
   logic [5:0]  frame_period;
   logic        tick4_s;
   logic [3:0]  level4_s;
   logic [5:0]  period4_s;

   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_q[$];
   int   m_cnt = 0;
   int   m_level = 0;
   logic mon_en = 1'b0;
   logic vs_prev = 1'b1;
   logic pend = 1'b0;

   fall_timer dut (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .points_in(points_in),
      .lock_en(lock_en), .soft_drop(soft_drop), .pause(pause),
      .drop_tick(drop_tick), .level(level), .frame_period(frame_period)
   );

   fall_timer #(.STEP_FRAMES(4)) dut_s4 (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .points_in(points_in),
      .lock_en(lock_en), .soft_drop(soft_drop), .pause(pause),
      .drop_tick(tick4_s), .level(level4_s), .frame_period(period4_s)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic int period_of(input int lvl, input int step, input logic sd);
      int b;
      b = 48 - step * lvl;
      if (b < 2) b = 2;
`ifdef FALL_TIMER_SOFT_DROP_EN
      if (sd && (b > 2)) b = 2;
`endif
      return b;
   endfunction

   // Monitor: one cycle after each vsync rise, pop the expected tick; elsewhere tick must be low
   always @(negedge pclk) begin
      if (mon_en) begin
         if (pend) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check("tick", int'(drop_tick), int'(exp_q.pop_front()));
            pend = 1'b0;
         end else begin
            check("tick_idle", int'(drop_tick), 0);
         end
         if (vsync_in && !vs_prev) pend = 1'b1;
         vs_prev = vsync_in;
      end
   end

   task automatic do_frame(input int rst_at, input logic lock);
      logic exp_tick;
      int   pts;
      exp_tick = 1'b0;
      if (lock) m_cnt = 0;
      else if (pause) m_cnt = m_cnt;
      else if (m_cnt + 1 >= period_of(m_level, 3, soft_drop)) begin
         m_cnt = 0;
         exp_tick = 1'b1;
      end else m_cnt++;
      exp_q.push_back(exp_tick);
      @(posedge pclk); #1;
      vsync_in = 1'b1;
      lock_en  = lock;
      for (int c = 1; c <= 20; c++) begin
         @(posedge pclk); #1;
         lock_en = 1'b0;
         rst     = (c == rst_at);
      end
      if (rst_at != 0) begin
         m_level = 0;
         m_cnt   = 0;
      end else begin
         pts = int'(points_in);
         m_level = (pts / 1000 > 15) ? 15 : pts / 1000;
      end
      check("level", int'(level), m_level);
      check("period", int'(frame_period), period_of(m_level, 3, soft_drop));
      check("period_s4", int'(period4_s), period_of(m_level, 4, soft_drop));
      vsync_in = 1'b0;
      repeat (20) @(posedge pclk);
      #1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (5) @(posedge pclk);
      #1;
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (5) @(posedge pclk);
      #1;
      vsync_in = 1'b0;
      repeat (10) @(posedge pclk);
      #1;
      check("rst_level", int'(level), 0);
      check("rst_period", int'(frame_period), 48);

      // Level 0: ticks after edges 48, 96, 144
      repeat (150) do_frame(0, 1'b0);

      // Level 2, then period 42
      points_in = 20'd2500;
      repeat (90) do_frame(0, 1'b0);

      // Saturation and clamp
      points_in = 20'd100000;
      repeat (10) do_frame(0, 1'b0);
      check("sat_level", int'(level), 15);
      check("sat_period", int'(frame_period), 3);
      check("sat_period_s4", int'(period4_s), 2);

      // Soft drop from frame_cnt = 30 at level 0
      points_in = 20'd0;
      do_frame(0, 1'b0);
      while (m_cnt != 30) do_frame(0, 1'b0);
      soft_drop = 1'b1;
      repeat (10) do_frame(0, 1'b0);
      soft_drop = 1'b0;
      repeat (100) do_frame(0, 1'b0);

      // Lock on the would-be tick edge
      while (m_cnt != 47) do_frame(0, 1'b0);
      do_frame(0, 1'b1);
      repeat (48) do_frame(0, 1'b0);

      // Pause freezes the count
      repeat (10) do_frame(0, 1'b0);
      pause = 1'b1;
      repeat (100) do_frame(0, 1'b0);
      pause = 1'b0;
      repeat (60) do_frame(0, 1'b0);

      // Reset three cycles into the level calculation
      points_in = 20'd9000;
      do_frame(3, 1'b0);
      check("rstcalc_level", int'(level), 0);
      check("rstcalc_tick", int'(drop_tick), 0);
      do_frame(0, 1'b0);
      check("lvl9_level", int'(level), 9);
      check("lvl9_period", int'(frame_period), 21);
      repeat (45) do_frame(0, 1'b0);

      repeat (5) @(posedge pclk);
      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
